// File: rtl/ball_bounce_engine.sv
// Per-step ball physics: probes brick memory at up to four leading-edge
// points, then resolves wall, platform, ceiling, floor and brick bounces
// into the ball direction registers.
module ball_bounce_engine #(
  parameter int COORD_W   = 10,
  parameter int SIZE_W    = 4,
  parameter int HEALTH_W  = 2,
  parameter int BRICK_XSH = 4,
  parameter int BRICK_YSH = 3,
  parameter int PLAT_W    = 32,
  parameter int PLAT_Y    = 220,
  parameter int MEM_LAT   = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [COORD_W-1:0]  ball_x,
  input  logic [COORD_W-1:0]  ball_y,
  input  logic [SIZE_W-1:0]   size,
  input  logic [COORD_W-1:0]  x_max,
  input  logic [COORD_W-1:0]  y_max,
  input  logic [COORD_W-1:0]  plat_x,
  output logic                mem_rd,
  output logic [COORD_W-1:0]  mem_x,
  output logic [COORD_W-1:0]  mem_y,
  input  logic [HEALTH_W-1:0] health,
  output logic                x_dir,
  output logic                y_dir,
  output logic                hit_valid,
  output logic [COORD_W-1:0]  hit_x,
  output logic [COORD_W-1:0]  hit_y,
  output logic                hit_axis,
  output logic                miss,
  output logic                busy,
  output logic                done
);

  // One extra bit so edges and sums never wrap; y-1 at y=0 becomes all-ones
  // and therefore fails the range check like any other out-of-field probe.
  localparam int EW = COORD_W + 1;
  localparam int CW = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
  localparam logic [EW-1:0] ONE = EW'(1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, UPDATE, DONE} state_t;
  state_t state, state_nx;

  logic [COORD_W-1:0] lx, ly, lxm, lym, lpx;
  logic [SIZE_W-1:0]  lsz;
  logic [1:0]         idx;
  logic [CW-1:0]      cnt;
  logic               y_hit, x_hit;
  logic [EW-1:0]      ycell_x, ycell_y;

  logic               sel;
  logic [EW-1:0]      sx, sy, ssz, sxm, sym, ye, xe, cx, cy;
  logic [EW-1:0]      px [4];
  logic [EW-1:0]      py [4];
  logic [3:0]         valid, avail;
  logic [1:0]         first_idx;
  logic               any, cur_hit, supp;
  logic [EW-1:0]      xs, ys, plat_lo, plat_hi;
  logic               overlap, x_dir_nx, y_dir_nx, miss_nx;

  // Probe geometry: live inputs while idle (to pick the first probe), latched copy afterwards
  always_comb begin
    sel = (state == IDLE);
    sx  = {1'b0, sel ? ball_x : lx};
    sy  = {1'b0, sel ? ball_y : ly};
    sxm = {1'b0, sel ? x_max  : lxm};
    sym = {1'b0, sel ? y_max  : lym};
    ssz = EW'(sel ? size : lsz);
    ye  = y_dir ? sy + ssz : sy - ONE;
    xe  = x_dir ? sx + ssz : sx - ONE;
    px[0] = sx;              py[0] = ye;
    px[1] = sx + ssz - ONE;  py[1] = ye;
    px[2] = xe;              py[2] = sy;
    px[3] = xe;              py[3] = sy + ssz - ONE;
    for (int i = 0; i < 4; i++) valid[i] = (px[i] < sxm) && (py[i] < sym);
    cx = px[idx];
    cy = py[idx];
  end

  // Hit detection, corner dedupe and selection of the next unskipped probe
  always_comb begin
    cur_hit = (health != '0);
    supp = y_hit && ((cx >> BRICK_XSH) == (ycell_x >> BRICK_XSH))
                 && ((cy >> BRICK_YSH) == (ycell_y >> BRICK_YSH));
    avail = valid;
    if (!sel) begin
      if (idx == 2'd0 && cur_hit) avail[1] = 1'b0;
      if (idx == 2'd2 && cur_hit) avail[3] = 1'b0;
      for (int i = 0; i < 4; i++) if (i <= int'(idx)) avail[i] = 1'b0;
    end
    any = |avail;
    first_idx = 2'd0;
    for (int i = 3; i >= 0; i--) if (avail[i]) first_idx = 2'(i);
  end

  // Direction resolution from the latched step inputs
  always_comb begin
    xs      = sx + ssz;
    ys      = sy + ssz;
    plat_lo = {1'b0, lpx};
    plat_hi = plat_lo + EW'(PLAT_W - 1);
    overlap = (sx <= plat_hi) && (sx + ssz - ONE >= plat_lo);
    if (xs >= sxm)         x_dir_nx = 1'b0;
    else if (sx == '0)     x_dir_nx = 1'b1;
    else                   x_dir_nx = x_dir ^ x_hit;
    miss_nx = 1'b0;
    if (y_dir && ys >= sym) begin
      y_dir_nx = 1'b0;
      miss_nx  = 1'b1;
    end else if (y_dir && ys == EW'(PLAT_Y) && overlap) y_dir_nx = 1'b0;
    else if (sy == '0)     y_dir_nx = 1'b1;
    else                   y_dir_nx = y_dir ^ y_hit;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = any ? ISSUE : UPDATE;
      ISSUE:   state_nx = (MEM_LAT > 1) ? WAIT : CHECK;
      WAIT:    if (cnt == CW'(MEM_LAT - 2)) state_nx = CHECK;
      CHECK:   state_nx = any ? ISSUE : UPDATE;
      UPDATE:  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    mem_rd = (state == ISSUE);
    mem_x  = mem_rd ? cx[COORD_W-1:0] : '0;
    mem_y  = mem_rd ? cy[COORD_W-1:0] : '0;
    busy   = (state != IDLE);
    done   = (state == DONE);
  end

  // Step datapath: input latch, probe index, latency counter, Y-hit location
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      lx  <= ball_x;
      ly  <= ball_y;
      lsz <= size;
      lxm <= x_max;
      lym <= y_max;
      lpx <= plat_x;
    end
    if ((state == IDLE && start) || state == CHECK) idx <= first_idx;
    if (state == ISSUE)     cnt <= '0;
    else if (state == WAIT) cnt <= cnt + CW'(1);
    if (state == CHECK && cur_hit && !idx[1]) begin
      ycell_x <= cx;
      ycell_y <= cy;
    end
  end

  // Control and registered outputs: hit reporting, hit flags, directions, miss
  always_ff @(posedge clk) begin
    if (!resetn) begin
      x_dir     <= 1'b1;
      y_dir     <= 1'b0;
      hit_valid <= 1'b0;
      hit_x     <= '0;
      hit_y     <= '0;
      hit_axis  <= 1'b0;
      miss      <= 1'b0;
      y_hit     <= 1'b0;
      x_hit     <= 1'b0;
    end else begin
      hit_valid <= 1'b0;
      miss      <= 1'b0;
      if (state == IDLE && start) begin
        y_hit <= 1'b0;
        x_hit <= 1'b0;
      end
      if (state == CHECK && cur_hit && (!idx[1] || !supp)) begin
        if (idx[1]) x_hit <= 1'b1;
        else        y_hit <= 1'b1;
        hit_valid <= 1'b1;
        hit_x     <= cx[COORD_W-1:0];
        hit_y     <= cy[COORD_W-1:0];
        hit_axis  <= idx[1];
      end
      if (state == UPDATE) begin
        x_dir <= x_dir_nx;
        y_dir <= y_dir_nx;
        miss  <= miss_nx;
      end
    end
  end

endmodule

// File: tb/tb_ball_bounce_engine.sv
// Directed bench for ball_bounce_engine at MEM_LAT=2, size=4, field 320x240.
module tb_ball_bounce_engine;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [9:0] ball_x = '0, ball_y = '0, plat_x = '0;
  logic [9:0] x_max = 10'd320, y_max = 10'd240;
  logic [3:0] size = 4'd4;
  logic       mem_rd, x_dir, y_dir, hit_valid, hit_axis, miss, busy, done;
  logic [9:0] mem_x, mem_y, hit_x, hit_y;
  logic [1:0] health;

  ball_bounce_engine #(.MEM_LAT(2)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .ball_x(ball_x), .ball_y(ball_y), .size(size),
    .x_max(x_max), .y_max(y_max), .plat_x(plat_x),
    .mem_rd(mem_rd), .mem_x(mem_x), .mem_y(mem_y), .health(health),
    .x_dir(x_dir), .y_dir(y_dir),
    .hit_valid(hit_valid), .hit_x(hit_x), .hit_y(hit_y), .hit_axis(hit_axis),
    .miss(miss), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Brick memory stub: two cells, health returned two cycles after the read
  int         b_cx [2];
  int         b_cy [2];
  logic [1:0] b_h  [2];
  logic [1:0] hp1 = '0, hp2 = '0;

  function automatic logic [1:0] look(input logic [9:0] x, input logic [9:0] y);
    for (int i = 0; i < 2; i++)
      if (b_h[i] != 0 && int'(x >> 4) == b_cx[i] && int'(y >> 3) == b_cy[i]) return b_h[i];
    return 2'd0;
  endfunction

  always @(posedge clk) begin
    hp1 <= mem_rd ? look(mem_x, mem_y) : 2'd0;
    hp2 <= hp1;
  end
  assign health = hp2;

  // Event monitors
  int rd_cnt = 0, hit_cnt = 0, miss_cnt = 0, done_cnt = 0;
  int rx [32];
  int ry [32];
  int lhx = 0, lhy = 0, lha = 0;

  always @(negedge clk) begin
    if (mem_rd) begin
      if (rd_cnt < 32) begin
        rx[rd_cnt] <= int'(mem_x);
        ry[rd_cnt] <= int'(mem_y);
      end
      rd_cnt <= rd_cnt + 1;
    end
    if (hit_valid) begin
      hit_cnt <= hit_cnt + 1;
      lhx <= int'(hit_x);
      lhy <= int'(hit_y);
      lha <= int'(hit_axis);
    end
    if (miss) miss_cnt <= miss_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_brick(input int cx, input int cy, input logic [1:0] h);
    b_cx[0] = cx;
    b_cy[0] = cy;
    b_h[0]  = h;
  endtask

  // Runs one step; lat = cycles from the start edge to the done cycle, -1 on timeout
  task automatic step(input int bx, input int by, input int pxv, input bit poke, output int lat);
    @(negedge clk);
    ball_x = bx[9:0];
    ball_y = by[9:0];
    plat_x = pxv[9:0];
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      start = (poke && lat == 5);
    end
    start = 1'b0;
    if (!done) lat = -1;
    @(negedge clk);
  endtask

  initial begin
    int lat, base, h0, d0, m0;
    b_h[0] = 2'd0; b_h[1] = 2'd0;
    b_cx[0] = 0; b_cy[0] = 0; b_cx[1] = 0; b_cy[1] = 0;

    repeat (3) @(negedge clk);
    chk("rst_x_dir", x_dir, 1);
    chk("rst_y_dir", y_dir, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_hit_valid", hit_valid, 0);
    chk("rst_miss", miss, 0);
    chk("rst_hit_x", hit_x, 0);
    resetn = 1'b1;

    // Ceiling bounce from reset directions: only P2/P3 issued
    base = rd_cnt;
    step(100, 0, 0, 0, lat);
    chk("ceil_lat", lat, 8);
    chk("ceil_reads", rd_cnt - base, 2);
    chk("ceil_x_dir", x_dir, 1);
    chk("ceil_y_dir", y_dir, 1);

    // Free flight with a dropped start while busy
    base = rd_cnt; d0 = done_cnt;
    step(100, 100, 0, 1, lat);
    chk("free_lat", lat, 14);
    chk("free_reads", rd_cnt - base, 4);
    chk("free_p0x", rx[base], 100);   chk("free_p0y", ry[base], 104);
    chk("free_p1x", rx[base+1], 103); chk("free_p1y", ry[base+1], 104);
    chk("free_p2x", rx[base+2], 104); chk("free_p2y", ry[base+2], 100);
    chk("free_p3x", rx[base+3], 104); chk("free_p3y", ry[base+3], 103);
    chk("free_x_dir", x_dir, 1);
    chk("free_y_dir", y_dir, 1);
    repeat (12) @(negedge clk);
    chk("busy_drop_done", done_cnt - d0, 1);
    chk("busy_drop_reads", rd_cnt - base, 4);
    chk("busy_drop_idle", busy, 0);

    // Y brick hit at cell (6,13)
    set_brick(6, 13, 2'd2);
    base = rd_cnt; h0 = hit_cnt;
    step(100, 100, 0, 0, lat);
    chk("yhit_lat", lat, 11);
    chk("yhit_reads", rd_cnt - base, 3);
    chk("yhit_p2x", rx[base+1], 104);
    chk("yhit_p2y", ry[base+1], 100);
    chk("yhit_count", hit_cnt - h0, 1);
    chk("yhit_x", lhx, 100);
    chk("yhit_y", lhy, 104);
    chk("yhit_axis", lha, 0);
    chk("yhit_x_dir", x_dir, 1);
    chk("yhit_y_dir", y_dir, 0);

    // Corner: P0 and P2 land in the same cell, only the Y hit is reported
    h0 = hit_cnt;
    step(100, 105, 0, 0, lat);
    chk("corner_count", hit_cnt - h0, 1);
    chk("corner_axis", lha, 0);
    chk("corner_y", lhy, 104);
    chk("corner_x_dir", x_dir, 1);
    chk("corner_y_dir", y_dir, 1);

    // Reset during WAIT discards the pending hit and the step
    h0 = hit_cnt; d0 = done_cnt;
    @(negedge clk);
    ball_x = 10'd100; ball_y = 10'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rstmid_issue", mem_rd, 1);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", busy, 0);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    chk("rstmid_hits", hit_cnt - h0, 0);
    chk("rstmid_done", done_cnt - d0, 0);
    chk("rstmid_x_dir", x_dir, 1);
    chk("rstmid_y_dir", y_dir, 0);

    // Right wall and ceiling together: every probe out of range
    set_brick(0, 0, 2'd0);
    base = rd_cnt;
    step(316, 0, 0, 0, lat);
    chk("wall_lat", lat, 2);
    chk("wall_reads", rd_cnt - base, 0);
    chk("wall_x_dir", x_dir, 0);
    chk("wall_y_dir", y_dir, 1);

    // Platform contact with a brick under P0: set, not double toggle
    set_brick(9, 27, 2'd1);
    h0 = hit_cnt;
    step(150, 216, 140, 0, lat);
    chk("plat_hits", hit_cnt - h0, 1);
    chk("plat_hit_x", lhx, 150);
    chk("plat_hit_y", lhy, 220);
    chk("plat_y_dir", y_dir, 0);
    chk("plat_x_dir", x_dir, 0);

    // Turn downward again, then reach the floor
    set_brick(0, 0, 2'd0);
    step(150, 0, 140, 0, lat);
    chk("ceil2_y_dir", y_dir, 1);
    m0 = miss_cnt; base = rd_cnt;
    step(150, 236, 140, 0, lat);
    chk("floor_miss", miss_cnt - m0, 1);
    chk("floor_lat", lat, 8);
    chk("floor_reads", rd_cnt - base, 2);
    chk("floor_y_dir", y_dir, 0);
    chk("floor_x_dir", x_dir, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
